// File: rtl/exc_pkg.sv
// Shared types and constants for the exception-entry sequencer.
package exc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWait,
        StLoad
    } exc_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_DIVZERO  = 2'b11;

    localparam logic [31:0] DEF_VEC_OPCODE   = 32'd253;
    localparam logic [31:0] DEF_VEC_OVERFLOW = 32'd254;
    localparam logic [31:0] DEF_VEC_DIVZERO  = 32'd255;

endpackage

// File: rtl/exception_sequencer_if.sv
// Bundle between control/datapath and the exception sequencer.
interface exception_sequencer_if;

    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_divzero;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] pc_target;
    logic        ex_sel;
    logic        pc_write;
    logic        busy;

    modport slave (
        input  exc_opcode, exc_overflow, exc_divzero, pc_in, mem_data_in,
        output mem_addr, mem_rd, epc, cause, pc_target, ex_sel, pc_write, busy
    );

    modport master (
        output exc_opcode, exc_overflow, exc_divzero, pc_in, mem_data_in,
        input  mem_addr, mem_rd, epc, cause, pc_target, ex_sel, pc_write, busy
    );

endinterface

// File: rtl/exc_priority_encoder.sv
// Maps the three exception flags to a cause code; opcode > overflow > divzero.
module exc_priority_encoder
    import exc_pkg::*;
(
    input  logic       opcode_i,
    input  logic       overflow_i,
    input  logic       divzero_i,
    output logic [1:0] cause_o,
    output logic       valid_o
);

    always_comb begin
        cause_o = CAUSE_NONE;
        if (opcode_i) begin
            cause_o = CAUSE_OPCODE;
        end else if (overflow_i) begin
            cause_o = CAUSE_OVERFLOW;
        end else if (divzero_i) begin
            cause_o = CAUSE_DIVZERO;
        end
    end

    assign valid_o = opcode_i | overflow_i | divzero_i;

endmodule

// File: rtl/exception_sequencer.sv
// Exception-entry sequencer: saves EPC, fetches the handler byte from the vector
// address and drives the PC-source mux select and PC write for one cycle.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE   = DEF_VEC_OPCODE,
    parameter logic [31:0] VEC_OVERFLOW = DEF_VEC_OVERFLOW,
    parameter logic [31:0] VEC_DIVZERO  = DEF_VEC_DIVZERO,
    parameter int unsigned MEM_WAIT     = 2
) (
    input logic                  clk,
    input logic                  reset,
    exception_sequencer_if.slave bus
);

    // MEM_WAIT must be >= 1; the counter holds MEM_WAIT-1 down to 0.
    localparam int unsigned   CntW    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(MEM_WAIT - 1);

    exc_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;
    logic [31:0]     pc_target_q, pc_target_d;
    logic [31:0]     mem_addr_q, mem_addr_d;

    logic [1:0]  enc_cause;
    logic        enc_valid;
    logic [31:0] vec_addr;
    logic        unused_mem_hi;

    exc_priority_encoder u_prio (
        .opcode_i   (bus.exc_opcode),
        .overflow_i (bus.exc_overflow),
        .divzero_i  (bus.exc_divzero),
        .cause_o    (enc_cause),
        .valid_o    (enc_valid)
    );

    always_comb begin
        vec_addr = '0;
        unique case (enc_cause)
            CAUSE_OPCODE:   vec_addr = VEC_OPCODE;
            CAUSE_OVERFLOW: vec_addr = VEC_OVERFLOW;
            CAUSE_DIVZERO:  vec_addr = VEC_DIVZERO;
            default:        vec_addr = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        pc_target_d = pc_target_q;
        mem_addr_d  = mem_addr_q;

        unique case (state_q)
            StIdle: begin
                // Flags are only looked at here; anything raised while busy is dropped.
                if (enc_valid) begin
                    cause_d    = enc_cause;
                    epc_d      = bus.pc_in - 32'd4;
                    mem_addr_d = vec_addr;
                    state_d    = StRead;
                end
            end
            StRead: begin
                cnt_d   = CntInit;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    pc_target_d = {24'b0, bus.mem_data_in[7:0]};
                    state_d     = StLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            epc_q       <= '0;
            cause_q     <= CAUSE_NONE;
            pc_target_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            pc_target_q <= pc_target_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Only the low byte of the vector entry is the handler address.
    assign unused_mem_hi = ^bus.mem_data_in[31:8];

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = (state_q == StRead) || (state_q == StWait);
    assign bus.epc       = epc_q;
    assign bus.cause     = cause_q;
    assign bus.pc_target = pc_target_q;
    assign bus.ex_sel    = (state_q == StLoad);
    assign bus.pc_write  = (state_q == StLoad);
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: two instances (MEM_WAIT 2 and 1) against a
// cycles-since-acceptance model, plus directed scenarios with literal expectations.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_divzero;
    logic [31:0] pc_in, mem_data_in;

    always #5 clk = ~clk;

    exception_sequencer_if if_a ();
    exception_sequencer_if if_b ();

    assign if_a.exc_opcode   = exc_opcode;
    assign if_a.exc_overflow = exc_overflow;
    assign if_a.exc_divzero  = exc_divzero;
    assign if_a.pc_in        = pc_in;
    assign if_a.mem_data_in  = mem_data_in;
    assign if_b.exc_opcode   = exc_opcode;
    assign if_b.exc_overflow = exc_overflow;
    assign if_b.exc_divzero  = exc_divzero;
    assign if_b.pc_in        = pc_in;
    assign if_b.mem_data_in  = mem_data_in;

    exception_sequencer #(.MEM_WAIT(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    exception_sequencer #(.MEM_WAIT(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    logic [31:0] o_addr[2], o_epc[2], o_tgt[2];
    logic [1:0]  o_cause[2];
    logic        o_rd[2], o_sel[2], o_pw[2], o_busy[2];

    assign o_addr[0] = if_a.mem_addr;   assign o_addr[1] = if_b.mem_addr;
    assign o_epc[0]  = if_a.epc;        assign o_epc[1]  = if_b.epc;
    assign o_tgt[0]  = if_a.pc_target;  assign o_tgt[1]  = if_b.pc_target;
    assign o_cause[0] = if_a.cause;     assign o_cause[1] = if_b.cause;
    assign o_rd[0]   = if_a.mem_rd;     assign o_rd[1]   = if_b.mem_rd;
    assign o_sel[0]  = if_a.ex_sel;     assign o_sel[1]  = if_b.ex_sel;
    assign o_pw[0]   = if_a.pc_write;   assign o_pw[1]   = if_b.pc_write;
    assign o_busy[0] = if_a.busy;       assign o_busy[1] = if_b.busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase = cycles since the exception was accepted, 0 when idle.
    int          wlat[2] = '{2, 1};
    int          phase[2] = '{0, 0};
    logic [31:0] m_epc[2] = '{32'd0, 32'd0};
    logic [31:0] m_addr[2] = '{32'd0, 32'd0};
    logic [31:0] m_tgt[2] = '{32'd0, 32'd0};
    logic [1:0]  m_cause[2] = '{2'd0, 2'd0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                phase[i] = 0; m_epc[i] = 0; m_addr[i] = 0; m_tgt[i] = 0; m_cause[i] = 0;
            end else if (phase[i] == 0) begin
                if (exc_opcode || exc_overflow || exc_divzero) begin
                    if (exc_opcode) m_cause[i] = 2'd1;
                    else if (exc_overflow) m_cause[i] = 2'd2;
                    else m_cause[i] = 2'd3;
                    m_epc[i]  = pc_in - 32'd4;
                    m_addr[i] = 32'd252 + 32'(m_cause[i]);
                    phase[i]  = 1;
                end
            end else if (phase[i] == 2 + wlat[i]) begin
                phase[i] = 0;
            end else begin
                if (phase[i] == 1 + wlat[i]) m_tgt[i] = {24'd0, mem_data_in[7:0]};
                phase[i] = phase[i] + 1;
            end
        end
    end

    int pw_cnt[2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (o_pw[i] === 1'b1) pw_cnt[i]++;
            if (cmp_en) begin
                check($sformatf("i%0d busy", i), 32'(o_busy[i]), 32'(phase[i] != 0));
                check($sformatf("i%0d mem_rd", i), 32'(o_rd[i]),
                      32'(phase[i] >= 1 && phase[i] <= 1 + wlat[i]));
                check($sformatf("i%0d ex_sel", i), 32'(o_sel[i]), 32'(phase[i] == 2 + wlat[i]));
                check($sformatf("i%0d pc_write", i), 32'(o_pw[i]), 32'(phase[i] == 2 + wlat[i]));
                check($sformatf("i%0d mem_addr", i), o_addr[i], m_addr[i]);
                check($sformatf("i%0d epc", i), o_epc[i], m_epc[i]);
                check($sformatf("i%0d cause", i), 32'(o_cause[i]), 32'(m_cause[i]));
                check($sformatf("i%0d pc_target", i), o_tgt[i], m_tgt[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && (o_busy[0] !== 1'b0 || o_busy[1] !== 1'b0); k++) tick();
        check("wait_idle bound", 32'(o_busy[0] | o_busy[1]), 32'd0);
    endtask

    int s;

    initial begin
        reset = 1'b1;
        exc_opcode = 0; exc_overflow = 0; exc_divzero = 0;
        pc_in = 0; mem_data_in = 0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset then idle
        check("rst busy", 32'(if_a.busy), 32'd0);
        check("rst mem_addr", if_a.mem_addr, 32'd0);
        check("rst epc", if_a.epc, 32'd0);
        check("rst cause", 32'(if_a.cause), 32'd0);
        check("rst pc_target", if_a.pc_target, 32'd0);
        repeat (10) tick();
        check("idle ex_sel", 32'(if_a.ex_sel), 32'd0);

        // Overflow entry
        pc_in = 32'h0000_0040; mem_data_in = 32'hABCD_1234; exc_overflow = 1;
        tick();
        exc_overflow = 0;
        check("ovf mem_addr c1", if_a.mem_addr, 32'd254);
        tick(); tick();
        check("ovf a pc_write c3", 32'(if_a.pc_write), 32'd0);
        check("ovf b pc_write c3", 32'(if_b.pc_write), 32'd1);
        tick();
        check("ovf a pc_write c4", 32'(if_a.pc_write), 32'd1);
        check("ovf a ex_sel c4", 32'(if_a.ex_sel), 32'd1);
        tick();
        check("ovf a pc_write c5", 32'(if_a.pc_write), 32'd0);
        check("ovf epc", if_a.epc, 32'h3C);
        check("ovf cause", 32'(if_a.cause), 32'd2);
        check("ovf pc_target", if_a.pc_target, 32'h34);
        check("ovf b pc_target", if_b.pc_target, 32'h34);

        // Simultaneous flags held through the sequence
        wait_idle();
        s = pw_cnt[0];
        pc_in = 32'h0000_2000;
        exc_opcode = 1; exc_overflow = 1; exc_divzero = 1;
        tick();
        check("sim cause", 32'(if_a.cause), 32'd1);
        check("sim mem_addr", if_a.mem_addr, 32'd253);
        tick(); tick(); tick();
        exc_opcode = 0; exc_overflow = 0; exc_divzero = 0;
        tick();
        check("sim single pc_write", 32'(pw_cnt[0] - s), 32'd1);
        check("sim back idle", 32'(if_a.busy), 32'd0);

        // Flags while busy are dropped
        wait_idle();
        s = pw_cnt[0];
        pc_in = 32'h0000_0100; exc_overflow = 1;
        tick();
        exc_overflow = 0; exc_divzero = 1;
        tick();
        exc_divzero = 0;
        tick();
        exc_divzero = 1;
        tick();
        exc_divzero = 0;
        check("busy cause kept", 32'(if_a.cause), 32'd2);
        repeat (3) tick();
        check("busy single pc_write", 32'(pw_cnt[0] - s), 32'd1);
        check("busy no resequence", 32'(if_a.busy), 32'd0);

        // Reset in the first WAIT cycle
        wait_idle();
        s = pw_cnt[0];
        pc_in = 32'h0000_1000; exc_divzero = 1;
        tick();
        exc_divzero = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("mid busy", 32'(if_a.busy), 32'd0);
        check("mid epc", if_a.epc, 32'd0);
        check("mid cause", 32'(if_a.cause), 32'd0);
        check("mid pc_target", if_a.pc_target, 32'd0);
        tick(); tick();
        check("mid no pc_write", 32'(pw_cnt[0] - s), 32'd0);

        // PC wrap; instance b has MEM_WAIT=1
        wait_idle();
        pc_in = 32'd0; mem_data_in = 32'h5A5A_5AC7; exc_opcode = 1;
        tick();
        exc_opcode = 0;
        tick(); tick();
        check("wrap b pc_write c3", 32'(if_b.pc_write), 32'd1);
        check("wrap b epc", if_b.epc, 32'hFFFF_FFFC);
        check("wrap b pc_target", if_b.pc_target, 32'hC7);
        check("wrap a pc_write c3", 32'(if_a.pc_write), 32'd0);
        tick();
        check("wrap a pc_write c4", 32'(if_a.pc_write), 32'd1);
        check("wrap a pc_target", if_a.pc_target, 32'hC7);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            exc_opcode   = ($urandom_range(0, 7) == 0);
            exc_overflow = ($urandom_range(0, 7) == 0);
            exc_divzero  = ($urandom_range(0, 7) == 0);
            pc_in        = $urandom;
            mem_data_in  = $urandom;
            reset        = ($urandom_range(0, 63) == 0);
            tick();
        end
        exc_opcode = 0; exc_overflow = 0; exc_divzero = 0; reset = 0;
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Multicycle sequencer for exception entry in the datapath, sitting directly upstream of the PC-source/exception mux.
- On an exception it saves the return address to EPC and reads the handler byte from the fixed vector address in memory.
- It presents that byte zero-extended as the mux's memory input, then drives the mux select and PC write for one cycle.
- Normal-flow PC updates pass untouched: the select stays 0 whenever the sequencer is idle.

Parameters:
- VEC_OPCODE, 32'd253, vector address for the invalid-opcode exception
- VEC_OVERFLOW, 32'd254, vector address for the ALU-overflow exception
- VEC_DIVZERO, 32'd255, vector address for the divide-by-zero exception
- MEM_WAIT, 2, memory read latency in cycles; must be at least 1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- exc_opcode  in  1  invalid-opcode flag from control; sampled only in IDLE
- exc_overflow  in  1  ALU overflow flag; sampled only in IDLE
- exc_divzero  in  1  divide-by-zero flag; sampled only in IDLE
- pc_in  in  32  current PC, already incremented by 4 at fetch
- mem_data_in  in  32  memory read data
- mem_addr  out  32  vector address driven to memory
- mem_rd  out  1  memory read strobe
- epc  out  32  saved exception PC
- cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 divzero
- pc_target  out  32  zero-extended handler byte; feeds the mux memory input
- ex_sel  out  1  mux select: 0 selects the PC-source path, 1 selects pc_target
- pc_write  out  1  PC register write enable for exception entry
- busy  out  1  high in every state except IDLE; control stalls on it

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE; epc, pc_target, mem_addr are 0; cause is 00; mem_rd, ex_sel, pc_write, busy are 0.
- All outputs are registered or decoded from the registered state only. There is no combinational path from exc_* inputs to outputs.
- IDLE:
  - If any exc_* flag is high at the clock edge: latch cause, set epc <= pc_in - 32'd4, then go to READ.
  - Priority when flags are simultaneous: opcode > overflow > divzero.
  - epc arithmetic is modulo 2^32, so pc_in = 0 gives epc = 32'hFFFFFFFC.
- READ (1 cycle):
  - mem_addr = vector for the latched cause; mem_rd = 1.
  - Load the wait counter with MEM_WAIT-1, then go to WAIT.
- WAIT (exactly MEM_WAIT cycles):
  - mem_addr is held and mem_rd stays 1; the counter decrements each cycle.
  - On the cycle the counter reads 0: pc_target <= {24'b0, mem_data_in[7:0]}, then go to LOAD.
- LOAD (1 cycle):
  - ex_sel = 1, pc_write = 1, mem_rd = 0, then go to IDLE.
  - busy stays high during LOAD.
- Latency: detection edge at cycle 0; LOAD, with pc_write high, occurs in cycle 2+MEM_WAIT (cycle 4 at the default).
- ex_sel and pc_write are high in LOAD only. Elsewhere ex_sel = 0 and pc_write = 0; normal PC writes are owned by control.
- epc, cause and pc_target hold their values after returning to IDLE, until the next exception is accepted.
- Exceptions asserted while busy are ignored (no nesting, no queuing). A flag still high on return to IDLE is accepted then.
- Reset mid-sequence returns to IDLE on that edge: no pc_write is issued, and epc, cause and pc_target are cleared.

Decomposition:
- Package exc_pkg holds:
  - state enum {IDLE, READ, WAIT, LOAD}
  - cause codes CAUSE_NONE/OPCODE/OVERFLOW/DIVZERO (2-bit)
  - default vector address constants 253/254/255
- One natural sub-module: exc_priority_encoder. It is combinational and maps the three flags to a 2-bit cause plus a valid bit. The FSM, counter and registers stay in exception_sequencer.

Test Plan:
- Reset then idle: assert reset 2 cycles, deassert -> all outputs 0, busy 0, ex_sel 0 throughout 10 idle cycles.
- Overflow: pc_in=32'h00000040, exc_overflow pulse, memory returns 32'hABCD1234 -> mem_addr=254 from cycle 1, epc=32'h3C, cause=10, pc_target=32'h34, pc_write and ex_sel high only in cycle 4.
- Simultaneous flags: exc_opcode, exc_overflow and exc_divzero all high together -> cause=01, mem_addr=253. Flags held high through the sequence cause exactly one pc_write before returning to IDLE.
- Ignored during busy: exc_divzero pulse in READ and another in WAIT -> cause unchanged, a single pc_write, no second sequence.
- Reset mid-sequence: reset in WAIT cycle 1 -> next cycle state IDLE, pc_write never asserted, epc=0, cause=00.
- Wrap and parameter: pc_in=0 with MEM_WAIT=1, exc_opcode -> epc=32'hFFFFFFFC, pc_write in cycle 3, pc_target equals mem_data_in[7:0] zero-extended.
